bcd_operand_entry: RTL and testbench



---
 rtl/bcd_operand_entry.sv | 171 +++++++++++++++++
 tb/tb_bcd_operand_entry.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry.sv
`default_nettype none
// ============================================================================
// Module      : bcd_operand_entry
// Description : Operand entry front end for the two-digit BCD adder.
//               Synchronizes switches and buttons, debounces LOAD/CLEAR,
//               and steps through X / Y capture while rejecting non-BCD
//               switch values.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       cin_sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       cin,
    output logic       valid,
    output logic       reject,
    output logic [1:0] entry_state
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_X = 2'd0,
        WAIT_Y = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Two-flop synchronizers; index 0 of the button vectors is LOAD, 1 is CLEAR
    logic [3:0] sw_meta_q,  sw_sync_q;
    logic       cin_meta_q, cin_sync_q;
    logic [1:0] btn_meta_q, btn_sync_q;
    logic [1:0] btn_pulse;

    // Bring every asynchronous input into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            cin_meta_q <= 1'b0;
            cin_sync_q <= 1'b0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            cin_meta_q <= cin_sw;
            cin_sync_q <= cin_meta_q;
            btn_meta_q <= {btn_clear, btn_load};
            btn_sync_q <= btn_meta_q;
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_debounce
            logic [CW-1:0] cnt_q;
            logic          stable_q;
            logic          stable_prev_q;

            // Flip the stable level only after a full run of differing samples
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q         <= '0;
                    stable_q      <= 1'b0;
                    stable_prev_q <= 1'b0;
                end else begin
                    stable_prev_q <= stable_q;
                    if (btn_sync_q[g] == stable_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        stable_q <= btn_sync_q[g];
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            // Rising edge of the debounced level: one pulse per press
            assign btn_pulse[g] = stable_q & ~stable_prev_q;
        end
    endgenerate

    logic   load_p, clear_p, digit_ok;
    state_t state_q, state_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic       cin_q, cin_d, valid_q, valid_d, reject_q, reject_d;

    assign load_p   = btn_pulse[0];
    assign clear_p  = btn_pulse[1];
    assign digit_ok = (sw_sync_q <= 4'd9);

    // Entry state and captured operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_X;
            x_q      <= '0;
            y_q      <= '0;
            cin_q    <= 1'b0;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cin_q    <= cin_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
        end
    end

    // Next-state logic; CLEAR wins over a coincident LOAD
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cin_d    = cin_q;
        valid_d  = valid_q;
        reject_d = 1'b0;
        if (clear_p) begin
            state_d = WAIT_X;
            x_d     = '0;
            y_d     = '0;
            cin_d   = 1'b0;
            valid_d = 1'b0;
        end else if (load_p) begin
            if (!digit_ok) begin
                reject_d = 1'b1;
            end else begin
                case (state_q)
                    WAIT_X: begin
                        x_d     = sw_sync_q;
                        state_d = WAIT_Y;
                    end
                    WAIT_Y: begin
                        y_d     = sw_sync_q;
                        cin_d   = cin_sync_q;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                    DONE: begin
                        x_d     = sw_sync_q;
                        y_d     = '0;
                        cin_d   = 1'b0;
                        valid_d = 1'b0;
                        state_d = WAIT_Y;
                    end
                    default: begin
                        state_d = WAIT_X;
                    end
                endcase
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign cin         = cin_q;
    assign valid       = valid_q;
    assign reject      = reject_q;
    assign entry_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_operand_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_operand_entry
// Description : Self-checking bench for bcd_operand_entry; expected outputs
//               are queued per press and compared at the capture edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_operand_entry;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       cin_sw, btn_load, btn_clear;
    logic [3:0] x, y;
    logic       cin, valid, reject;
    logic [1:0] entry_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       cin;
        logic       valid;
        logic [1:0] st;
        logic       rej;
    } exp_t;

    exp_t q[$];
    exp_t mdl;

    bcd_operand_entry #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .cin_sw      (cin_sw),
        .btn_load    (btn_load),
        .btn_clear   (btn_clear),
        .x           (x),
        .y           (y),
        .cin         (cin),
        .valid       (valid),
        .reject      (reject),
        .entry_state (entry_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".x"},      32'(x),           32'(e.x));
        chk({tag, ".y"},      32'(y),           32'(e.y));
        chk({tag, ".cin"},    32'(cin),         32'(e.cin));
        chk({tag, ".valid"},  32'(valid),       32'(e.valid));
        chk({tag, ".state"},  32'(entry_state), 32'(e.st));
        chk({tag, ".reject"}, 32'(reject),      32'(e.rej));
    endtask

    function automatic exp_t model_step(input exp_t m, input bit ld, input bit cl,
                                        input logic [3:0] s, input logic c);
        exp_t r;
        r     = m;
        r.rej = 1'b0;
        if (cl) begin
            r = '0;
        end else if (ld) begin
            if (s > 4'd9) begin
                r.rej = 1'b1;
            end else if (m.st == 2'd0) begin
                r.x  = s;
                r.st = 2'd1;
            end else if (m.st == 2'd1) begin
                r.y     = s;
                r.cin   = c;
                r.valid = 1'b1;
                r.st    = 2'd2;
            end else begin
                r.x     = s;
                r.y     = 4'd0;
                r.cin   = 1'b0;
                r.valid = 1'b0;
                r.st    = 2'd1;
            end
        end
        return r;
    endfunction

    task automatic capture(input string tag);
        exp_t e;
        chk({tag, ".sb_depth"}, 32'(q.size()), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk_all(tag, e);
        end
    endtask

    // One press of LOAD and/or CLEAR, optionally preceded by a bounce burst
    task automatic do_press(input string tag, input bit ld, input bit cl,
                            input logic [3:0] s, input logic c, input bit bounce);
        exp_t prev;
        sw     = s;
        cin_sw = c;
        prev   = mdl;
        if (bounce) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1 btn_load = 1'b1;
                @(posedge clk);
                @(posedge clk); #1 btn_load = 1'b0;
                @(posedge clk);
            end
            chk_all({tag, ".bounce"}, prev);
        end
        @(posedge clk); #1;
        btn_load  = ld;
        btn_clear = cl;
        q.push_back(model_step(mdl, ld, cl, s, c));
        mdl     = q[$];
        mdl.rej = 1'b0;
        repeat (DC + 2) @(posedge clk);
        #1 chk_all({tag, ".pre"}, prev);
        @(posedge clk); #1;
        capture(tag);
        @(posedge clk); #1;
        chk({tag, ".rej_once"}, 32'(reject), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (DC + 4) @(posedge clk);
        #1 chk_all({tag, ".post"}, mdl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        sw        = 4'd0;
        cin_sw    = 1'b0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        mdl       = '0;
        repeat (3) @(posedge clk);
        #1 chk_all("reset", mdl);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_press("ld_x7",      1, 0, 4'd7,  1'b0, 0);
        do_press("ld_y5",      1, 0, 4'd5,  1'b1, 0);
        do_press("clr_done",   0, 1, 4'd0,  1'b0, 0);
        do_press("rej_x12",    1, 0, 4'd12, 1'b0, 0);
        do_press("ld_x9",      1, 0, 4'd9,  1'b0, 0);
        do_press("rej_y10",    1, 0, 4'd10, 1'b1, 0);
        do_press("clr_wy",     0, 1, 4'd0,  1'b0, 0);
        do_press("ld_x3",      1, 0, 4'd3,  1'b0, 0);
        do_press("ld_y4",      1, 0, 4'd4,  1'b1, 0);
        do_press("rej_done15", 1, 0, 4'd15, 1'b0, 0);
        do_press("reent_x8",   1, 0, 4'd8,  1'b1, 0);
        do_press("bounce_y2",  1, 0, 4'd2,  1'b1, 1);
        do_press("reent_x1",   1, 0, 4'd1,  1'b0, 0);
        do_press("clr_pri",    1, 1, 4'd6,  1'b1, 0);
        do_press("ld_x5",      1, 0, 4'd5,  1'b0, 0);

        // Reset asserted part way through a LOAD debounce
        sw = 4'd6;
        @(posedge clk); #1 btn_load = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        mdl = '0;
        #1 chk_all("async_rst", mdl);
        @(posedge clk);
        #5 rst_n = 1'b1;
        q.push_back(model_step(mdl, 1'b1, 1'b0, 4'd6, 1'b0));
        repeat (DC + 2) @(posedge clk);
        #1 chk_all("rst_hold.pre", mdl);
        @(posedge clk); #1;
        capture("rst_hold");
        btn_load = 1'b0;
        repeat (DC + 4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
